// File: rtl/serial_alu_core.sv
// Bit-serial execution core: one register-file instruction at a time, operands
// streamed LSB-first through a 1-bit ALU with a registered carry.
module serial_alu_core #(
  parameter int WIDTH = 8,
  parameter int NREGS = 4,
  localparam int AW = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [2:0]       op,
  input  logic [AW-1:0]    rd,
  input  logic [AW-1:0]    rs1,
  input  logic [AW-1:0]    rs2,
  input  logic [WIDTH-1:0] imm,
  output logic [WIDTH-1:0] acc,
  output logic             carry_flag,
  output logic             zero_flag,
  output logic             done,
  input  logic [AW-1:0]    dbg_sel,
  output logic [WIDTH-1:0] dbg_data
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, LOAD, EXEC, WB} state_t;
  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_AND  = 3'd2,
    OP_OR   = 3'd3,
    OP_XOR  = 3'd4,
    OP_ADDI = 3'd5,
    OP_LI   = 3'd6,
    OP_MOV  = 3'd7
  } op_t;

  state_t           state_q, state_d;
  op_t              op_q;
  logic [AW-1:0]    rd_q, rs1_q, rs2_q;
  logic [WIDTH-1:0] imm_q;
  logic [WIDTH-1:0] a_sr, b_sr, r_sr;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] regs [NREGS];

  logic             last_bit;
  logic             is_arith;
  logic             b_eff;
  logic             alu_bit;
  logic             alu_cout;
  logic [WIDTH-1:0] a_load, b_load;

  assign instr_ready = (state_q == IDLE);
  assign dbg_data    = regs[dbg_sel];
  assign last_bit    = (cnt_q == CW'(WIDTH - 1));
  assign is_arith    = (op_q == OP_ADD) || (op_q == OP_SUB) || (op_q == OP_ADDI);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (instr_valid) state_d = LOAD;
      LOAD:    state_d = EXEC;
      EXEC:    if (last_bit) state_d = WB;
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // LI streams imm through A with B zeroed; MOV likewise with rs1, so the
  // ALU's pass-through path yields the result bits unchanged.
  always_comb begin
    a_load = (op_q == OP_LI) ? imm_q : regs[rs1_q];
    b_load = regs[rs2_q];
    if (op_q == OP_ADDI) b_load = imm_q;
    else if ((op_q == OP_LI) || (op_q == OP_MOV)) b_load = '0;
  end

  always_comb begin
    b_eff    = (op_q == OP_SUB) ? ~b_sr[0] : b_sr[0];
    alu_cout = (a_sr[0] & b_eff) | (a_sr[0] & carry_q) | (b_eff & carry_q);
    alu_bit  = a_sr[0];
    case (op_q)
      OP_ADD, OP_SUB, OP_ADDI: alu_bit = a_sr[0] ^ b_eff ^ carry_q;
      OP_AND:                  alu_bit = a_sr[0] & b_sr[0];
      OP_OR:                   alu_bit = a_sr[0] | b_sr[0];
      OP_XOR:                  alu_bit = a_sr[0] ^ b_sr[0];
      default:                 alu_bit = a_sr[0];
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      op_q       <= OP_ADD;
      rd_q       <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      imm_q      <= '0;
      a_sr       <= '0;
      b_sr       <= '0;
      r_sr       <= '0;
      carry_q    <= 1'b0;
      cnt_q      <= '0;
      acc        <= '0;
      carry_flag <= 1'b0;
      zero_flag  <= 1'b0;
      done       <= 1'b0;
    end else begin
      state_q <= state_d;
      done    <= (state_q == WB);
      case (state_q)
        IDLE: begin
          if (instr_valid) begin
            op_q  <= op_t'(op);
            rd_q  <= rd;
            rs1_q <= rs1;
            rs2_q <= rs2;
            imm_q <= imm;
          end
        end
        LOAD: begin
          a_sr    <= a_load;
          b_sr    <= b_load;
          cnt_q   <= '0;
          carry_q <= (op_q == OP_SUB);
        end
        EXEC: begin
          a_sr    <= a_sr >> 1;
          b_sr    <= b_sr >> 1;
          r_sr    <= {alu_bit, r_sr[WIDTH-1:1]};
          carry_q <= alu_cout;
          cnt_q   <= last_bit ? '0 : cnt_q + CW'(1);
        end
        WB: begin
          acc        <= r_sr;
          carry_flag <= is_arith ? carry_q : 1'b0;
          zero_flag  <= (r_sr == '0);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (state_q == WB) begin
      regs[rd_q] <= r_sr;
    end
  end

endmodule

// File: tb/tb_serial_alu_core.sv
// Randomized self-checking bench for serial_alu_core (8-bit/4-reg and 16-bit/8-reg
// instances) against an arithmetic reference model.
module tb_serial_alu_core;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       v8 = 1'b0, ready8, c8, z8, done8;
  logic [2:0] op8 = '0;
  logic [1:0] rd8 = '0, rs18 = '0, rs28 = '0, dsel8 = '0;
  logic [7:0] imm8 = '0, acc8, ddata8;

  logic        v16 = 1'b0, ready16, c16, z16, done16;
  logic [2:0]  op16 = '0, rd16 = '0, rs116 = '0, rs216 = '0, dsel16 = '0;
  logic [15:0] imm16 = '0, acc16, ddata16;

  serial_alu_core #(.WIDTH(8), .NREGS(4)) dut8 (
    .clk(clk), .rst_n(rst_n), .instr_valid(v8), .instr_ready(ready8),
    .op(op8), .rd(rd8), .rs1(rs18), .rs2(rs28), .imm(imm8),
    .acc(acc8), .carry_flag(c8), .zero_flag(z8), .done(done8),
    .dbg_sel(dsel8), .dbg_data(ddata8)
  );

  serial_alu_core #(.WIDTH(16), .NREGS(8)) dut16 (
    .clk(clk), .rst_n(rst_n), .instr_valid(v16), .instr_ready(ready16),
    .op(op16), .rd(rd16), .rs1(rs116), .rs2(rs216), .imm(imm16),
    .acc(acc16), .carry_flag(c16), .zero_flag(z16), .done(done16),
    .dbg_sel(dsel16), .dbg_data(ddata16)
  );

  int n_cmp = 0;
  int n_bad = 0;
  longint m8 [4];
  longint m16 [8];

  // Returns result in bits [w-1:0] and carry flag in bit w.
  function automatic longint ref_op(input int w, input int o, input longint a,
                                    input longint b, input longint im);
    longint mask, s, res;
    bit c;
    mask = (longint'(1) << w) - 1;
    c = 1'b0;
    case (o)
      0: begin s = a + b;  res = s & mask; c = ((s >> w) & 1) != 0; end
      1: begin res = (a - b) & mask; c = (a >= b); end
      2: res = a & b;
      3: res = a | b;
      4: res = a ^ b;
      5: begin s = a + im; res = s & mask; c = ((s >> w) & 1) != 0; end
      6: res = im & mask;
      default: res = a;
    endcase
    return res | (longint'(c) << w);
  endfunction

  task automatic zero_models();
    for (int i = 0; i < 4; i++) m8[i] = 0;
    for (int i = 0; i < 8; i++) m16[i] = 0;
  endtask

  task automatic exec8(input int o, input int d, input int s1, input int s2, input longint im);
    int t, cyc;
    longint r, res;
    bit c;
    t = 0;
    while (ready8 !== 1'b1 && t < 50) begin @(posedge clk); #1; t++; end
    if (ready8 !== 1'b1) begin
      n_cmp++; n_bad++;
      $display("FAIL ready_wait8: ready=%b required 1", ready8);
    end
    op8 = 3'(o); rd8 = 2'(d); rs18 = 2'(s1); rs28 = 2'(s2); imm8 = 8'(im); v8 = 1'b1;
    r = ref_op(8, o, m8[s1], m8[s2], im & 'hFF);
    res = r & 'hFF;
    c = r[8];
    m8[d] = res;
    @(posedge clk); #1;
    v8 = 1'b0;
    cyc = 1;
    while (done8 !== 1'b1 && cyc < 40) begin
      n_cmp++;
      if (ready8 !== 1'b0) begin
        n_bad++; $display("FAIL busy_ready8 cyc=%0d: got %b required 0", cyc, ready8);
      end
      @(posedge clk); #1;
      cyc++;
    end
    n_cmp++;
    if (cyc !== 11) begin n_bad++; $display("FAIL latency8 op=%0d: got %0d required 11", o, cyc); end
    n_cmp++;
    if (acc8 !== 8'(res)) begin n_bad++; $display("FAIL acc8 op=%0d: got %h required %h", o, acc8, 8'(res)); end
    n_cmp++;
    if (c8 !== c) begin n_bad++; $display("FAIL carry8 op=%0d: got %b required %b", o, c8, c); end
    n_cmp++;
    if (z8 !== (res == 0)) begin n_bad++; $display("FAIL zero8 op=%0d: got %b required %b", o, z8, res == 0); end
    n_cmp++;
    if (ready8 !== 1'b1) begin n_bad++; $display("FAIL done_ready8: got %b required 1", ready8); end
    dsel8 = 2'(d);
    #1;
    n_cmp++;
    if (ddata8 !== 8'(m8[d])) begin n_bad++; $display("FAIL dbg8 r%0d: got %h required %h", d, ddata8, 8'(m8[d])); end
    @(posedge clk); #1;
    n_cmp++;
    if (done8 !== 1'b0) begin n_bad++; $display("FAIL done_width8: got %b required 0", done8); end
  endtask

  task automatic exec16(input int o, input int d, input int s1, input int s2, input longint im);
    int t, cyc;
    longint r, res;
    bit c;
    t = 0;
    while (ready16 !== 1'b1 && t < 50) begin @(posedge clk); #1; t++; end
    if (ready16 !== 1'b1) begin
      n_cmp++; n_bad++;
      $display("FAIL ready_wait16: ready=%b required 1", ready16);
    end
    op16 = 3'(o); rd16 = 3'(d); rs116 = 3'(s1); rs216 = 3'(s2); imm16 = 16'(im); v16 = 1'b1;
    r = ref_op(16, o, m16[s1], m16[s2], im & 'hFFFF);
    res = r & 'hFFFF;
    c = r[16];
    m16[d] = res;
    @(posedge clk); #1;
    v16 = 1'b0;
    cyc = 1;
    while (done16 !== 1'b1 && cyc < 60) begin @(posedge clk); #1; cyc++; end
    n_cmp++;
    if (cyc !== 19) begin n_bad++; $display("FAIL latency16 op=%0d: got %0d required 19", o, cyc); end
    n_cmp++;
    if (acc16 !== 16'(res)) begin n_bad++; $display("FAIL acc16 op=%0d: got %h required %h", o, acc16, 16'(res)); end
    n_cmp++;
    if (c16 !== c) begin n_bad++; $display("FAIL carry16 op=%0d: got %b required %b", o, c16, c); end
    n_cmp++;
    if (z16 !== (res == 0)) begin n_bad++; $display("FAIL zero16 op=%0d: got %b required %b", o, z16, res == 0); end
    dsel16 = 3'(d);
    #1;
    n_cmp++;
    if (ddata16 !== 16'(m16[d])) begin n_bad++; $display("FAIL dbg16 r%0d: got %h required %h", d, ddata16, 16'(m16[d])); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    zero_models();
    n_cmp++;
    if (ready8 !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b required 1", ready8); end
    n_cmp++;
    if (done8 !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b required 0", done8); end
    n_cmp++;
    if (acc8 !== 8'h00) begin n_bad++; $display("FAIL reset_acc: got %h required 00", acc8); end
    n_cmp++;
    if ({c8, z8} !== 2'b00) begin n_bad++; $display("FAIL reset_flags: got %b required 00", {c8, z8}); end
    for (int i = 0; i < 4; i++) begin
      dsel8 = 2'(i);
      #1;
      n_cmp++;
      if (ddata8 !== 8'h00) begin n_bad++; $display("FAIL reset_reg r%0d: got %h required 00", i, ddata8); end
    end
  endtask

  task automatic test_basic();
    exec8(6, 1, 0, 0, 'h5A);
    exec8(6, 2, 0, 0, 'hA5);
    exec8(0, 3, 1, 2, 0);
    n_cmp++;
    if (acc8 !== 8'hFF) begin n_bad++; $display("FAIL basic_add: got %h required ff", acc8); end
  endtask

  task automatic test_carry_sub();
    exec8(6, 1, 0, 0, 'hFF);
    exec8(5, 2, 1, 0, 'h01);
    n_cmp++;
    if ({acc8, c8, z8} !== {8'h00, 2'b11}) begin
      n_bad++; $display("FAIL addi_wrap: got %h/%b%b required 00/11", acc8, c8, z8);
    end
    exec8(1, 0, 1, 1, 0);
    exec8(1, 3, 0, 1, 0);
    n_cmp++;
    if ({acc8, c8, z8} !== {8'h01, 2'b00}) begin
      n_bad++; $display("FAIL sub_borrow: got %h/%b%b required 01/00", acc8, c8, z8);
    end
  endtask

  task automatic test_logic();
    exec8(6, 1, 0, 0, 'hF0);
    exec8(6, 2, 0, 0, 'h3C);
    exec8(2, 3, 1, 2, 0);
    n_cmp++;
    if (acc8 !== 8'h30) begin n_bad++; $display("FAIL and: got %h required 30", acc8); end
    exec8(3, 3, 1, 2, 0);
    n_cmp++;
    if (acc8 !== 8'hFC) begin n_bad++; $display("FAIL or: got %h required fc", acc8); end
    exec8(4, 3, 1, 2, 0);
    n_cmp++;
    if (acc8 !== 8'hCC) begin n_bad++; $display("FAIL xor: got %h required cc", acc8); end
    exec8(7, 0, 3, 0, 0);
  endtask

  task automatic test_random();
    for (int k = 0; k < 30; k++)
      exec8($urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 3), longint'($urandom_range(0, 255)));
    for (int i = 0; i < 4; i++) begin
      dsel8 = 2'(i);
      #1;
      n_cmp++;
      if (ddata8 !== 8'(m8[i])) begin n_bad++; $display("FAIL rand_reg r%0d: got %h required %h", i, ddata8, 8'(m8[i])); end
    end
  endtask

  // Valid held high with fresh fields every cycle: accepts land every 11 edges.
  task automatic test_back_to_back();
    longint r, exp_res;
    bit exp_c;
    exp_res = 0;
    exp_c = 1'b0;
    for (int e = 0; e < 3 * 11; e++) begin
      op8 = 3'($urandom_range(0, 7));
      rd8 = 2'($urandom_range(0, 3));
      rs18 = 2'($urandom_range(0, 3));
      rs28 = 2'($urandom_range(0, 3));
      imm8 = 8'($urandom_range(0, 255));
      v8 = 1'b1;
      n_cmp++;
      if (ready8 !== ((e % 11) == 0)) begin
        n_bad++; $display("FAIL b2b_ready e=%0d: got %b required %b", e, ready8, (e % 11) == 0);
      end
      if ((e % 11) == 0) begin
        r = ref_op(8, int'(op8), m8[rs18], m8[rs28], longint'(imm8));
        exp_res = r & 'hFF;
        exp_c = r[8];
        m8[rd8] = exp_res;
      end
      @(posedge clk); #1;
      n_cmp++;
      if (done8 !== ((e % 11) == 10)) begin
        n_bad++; $display("FAIL b2b_done e=%0d: got %b required %b", e, done8, (e % 11) == 10);
      end
      if ((e % 11) == 10) begin
        n_cmp++;
        if ({acc8, c8} !== {8'(exp_res), exp_c}) begin
          n_bad++; $display("FAIL b2b_result: got %h/%b required %h/%b", acc8, c8, 8'(exp_res), exp_c);
        end
      end
    end
    v8 = 1'b0;
    @(posedge clk); #1;
    exec8(6, 1, 0, 0, 'h41);
    exec8(0, 1, 1, 1, 0);
    n_cmp++;
    if (acc8 !== 8'h82) begin n_bad++; $display("FAIL inplace_add: got %h required 82", acc8); end
  endtask

  task automatic test_abort();
    exec8(6, 2, 0, 0, 'h33);
    exec8(6, 3, 0, 0, 'h44);
    op8 = 3'd0; rd8 = 2'd1; rs18 = 2'd2; rs28 = 2'd3; v8 = 1'b1;
    @(posedge clk); #1;
    v8 = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    zero_models();
    for (int k = 0; k < 15; k++) begin
      n_cmp++;
      if (done8 !== 1'b0) begin n_bad++; $display("FAIL abort_done k=%0d: got %b required 0", k, done8); end
      @(posedge clk); #1;
    end
    n_cmp++;
    if ({ready8, acc8, c8, z8} !== {1'b1, 8'h00, 2'b00}) begin
      n_bad++; $display("FAIL abort_state: got %b/%h/%b%b required 1/00/00", ready8, acc8, c8, z8);
    end
    dsel8 = 2'd1;
    #1;
    n_cmp++;
    if (ddata8 !== 8'h00) begin n_bad++; $display("FAIL abort_r1: got %h required 00", ddata8); end
  endtask

  task automatic test_wide();
    exec16(6, 7, 0, 0, 'hFFFF);
    exec16(5, 6, 7, 0, 'h0002);
    n_cmp++;
    if ({acc16, c16} !== {16'h0001, 1'b1}) begin
      n_bad++; $display("FAIL wide_addi: got %h/%b required 0001/1", acc16, c16);
    end
    for (int k = 0; k < 6; k++)
      exec16($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
             $urandom_range(0, 7), longint'($urandom_range(0, 65535)));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_carry_sub();
    test_logic();
    test_random();
    test_back_to_back();
    test_abort();
    test_wide();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/serial_alu_core.md
# serial_alu_core

Parametrised bit-serial execution core, the successor to the fixed 8-bit bit-serial CPU datapath. It executes one register-file instruction at a time. Operands are processed LSB-first, one bit per clock, through a 1-bit ALU with a registered carry. The result goes to a destination register and an accumulator, with carry/zero flags. Instructions enter through a valid/ready handshake from the instruction decoder; results are observed on `acc`, the flags and a debug read port.

## Interface
- `WIDTH`, default 8: datapath width in bits; must be ≥ 2.
- `NREGS`, default 4: register count; must be a power of 2 and ≥ 2. `AW = $clog2(NREGS)`.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `instr_valid`  in  1  instruction fields are valid.
- `instr_ready`  out  1  core is idle and accepts an instruction.
- `op`  in  3  opcode.
- `rd`, `rs1`, `rs2`  in  AW each  destination and source register indices.
- `imm`  in  WIDTH  immediate value.
- `acc`  out  WIDTH  last written result.
- `carry_flag`, `zero_flag`  out  1 each  flags of the last instruction.
- `done`  out  1  one-cycle pulse; the result is visible.
- `dbg_sel`  in  AW  debug register select.
- `dbg_data`  out  WIDTH  combinational read of `reg[dbg_sel]`.

## Operation
- Opcodes:
  - 0 ADD: rs1+rs2.
  - 1 SUB: rs1+~rs2+1.
  - 2 AND.
  - 3 OR.
  - 4 XOR.
  - 5 ADDI: rs1+imm.
  - 6 LI: imm.
  - 7 MOV: rs1.
- Every opcode writes the result to both `reg[rd]` and `acc`.
- Register 0 is an ordinary register, not hardwired.
- FSM states: IDLE, LOAD, EXEC, WB.
  - IDLE→LOAD on `instr_valid && instr_ready`. `op`, `rd`, `rs1`, `rs2` and `imm` are captured at that edge.
  - LOAD→EXEC: operand shift registers A and B are loaded in parallel from the regfile/imm. The bit counter clears. The carry seeds to 1 for SUB and 0 otherwise.
  - EXEC: exactly WIDTH cycles. Each edge shifts A and B right by 1 and shifts the ALU bit into the MSB of result shift register R. Carry updates from the ALU carry-out. The counter increments.
  - EXEC→WB after the WIDTH-th shift; the counter wraps to 0.
  - WB→IDLE. At that edge `reg[rd]`, `acc`, `carry_flag` and `zero_flag` update, and `done` is registered high for the following cycle.
- Operands are latched in LOAD, so `rd` equal to `rs1` or `rs2` is safe.
- Width rules:
  - All arithmetic is modulo 2^WIDTH.
  - `carry_flag` is the carry out of the MSB for ADD/ADDI, and NOT-borrow for SUB (1 when rs1 ≥ rs2 unsigned).
  - `carry_flag` is 0 for AND/OR/XOR/LI/MOV.
  - `zero_flag` = (result == 0) for every opcode.
- `instr_ready` = (state == IDLE).
- `instr_valid` is ignored while not ready; no queueing.
- Reset:
  - state IDLE, counter 0, all registers 0.
  - `acc` 0, both flags 0, `done` 0, `instr_ready` 1 in the cycle after reset.
- Reset mid-instruction aborts it: no register, acc or flag write, and no `done`.
- `dbg_data` reflects a WB write in the cycle after the WB edge.

## Timing
- Accept at edge E0. LOAD edge is E1. EXEC edges are E2…E(WIDTH+1). The WB edge is E(WIDTH+2).
- `done`, new `acc`, new flags and `instr_ready`=1 are all asserted in the cycle after E(WIDTH+2).
- Accept-to-done latency is WIDTH+3 cycles: 11 for WIDTH=8.
- Back-to-back: a new instruction may be accepted on the edge ending the `done` cycle. Throughput is one instruction per WIDTH+3 cycles.
- `done` is exactly one cycle wide and never asserts without a prior accepted instruction.
- `acc` and the flags hold their values until the next WB edge.

## Test plan
- Reset, then LI r1,0x5A; LI r2,0xA5; ADD r3,r1,r2 (WIDTH=8) → `acc`=0xFF, C=0, Z=0, `dbg_data`(r3)=0xFF, and `done` exactly 11 cycles after each accept.
- LI r1,0xFF; ADDI r2,r1,0x01 → `acc`=0x00, C=1, Z=1. Then SUB r0,r1,r1 → 0x00, C=1, Z=1. SUB r3,r0,r1 (0−0xFF) → 0x01, C=0, Z=0.
- AND/OR/XOR of 0xF0 and 0x3C → 0x30, 0xFC and 0xCC respectively, C=0. MOV r0,r3 → r0 = r3 value.
- Hold `instr_valid` high continuously with changing fields → only instructions present on accept edges execute. `instr_ready` is low for cycles 1…WIDTH+2 after each accept. In-place ADD r1,r1,r1 with r1=0x41 → 0x82.
- Assert `rst_n`=0 during the 4th EXEC cycle of ADD r1,r2,r3 → no `done`, r1 unchanged at 0, `acc`=0, flags 0, `instr_ready`=1 after release.
- Instantiate WIDTH=16, NREGS=8: LI r7,0xFFFF; ADDI r6,r7,0x0002 → `acc`=0x0001, C=1, and latency is 19 cycles.
